// File: rtl/demux_pkg.sv
// Shared types and sizing for the registered 1-to-N lane demultiplexer.
package demux_pkg;

    localparam int W  = 5;
    localparam int N  = 10;
    localparam int SW = 4;

    typedef enum logic {FILL, DONE} demux_state_t;
    typedef logic [W-1:0] lane_t;

    // Auto-mode lane pointer advance; wraps after the last lane.
    function automatic logic [SW-1:0] ptr_next(input logic [SW-1:0] p);
        return (p == SW'(N - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/demux_dec.sv
// Select-to-lane one-hot decoder; in_range is low when sel has no matching lane.
module demux_dec
    import demux_pkg::*;
(
    input  logic [SW-1:0] sel,
    output logic [N-1:0]  onehot,
    output logic          in_range
);

    always_comb begin
        onehot   = '0;
        in_range = (int'(sel) < N);
        for (int k = 0; k < N; k++) begin
            if (sel == SW'(k)) onehot[k] = 1'b1;
        end
    end

endmodule

// File: rtl/demux_seq.sv
// Registered 1-to-N demultiplexer that assembles an N-lane frame from single-word beats.
// state | meaning
// FILL  | accepting beats, lanes filling
// DONE  | frame complete for one cycle; beats refused, lane_valid/ptr restart next cycle
module demux_seq
    import demux_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            auto_mode,
    input  logic [SW-1:0]   S,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    D,
    output logic [N*W-1:0]  Q,
    output logic [N-1:0]    lane_valid,
    output logic            frame_done,
    output logic            err_sel
);

    demux_state_t  state, state_nxt;
    logic [SW-1:0] ptr, ptr_nxt;
    logic [N-1:0]  lv_nxt;
    logic [N-1:0]  sel_oh;
    logic [N-1:0]  wr_en;
    logic [SW-1:0] idx;
    logic          sel_ok;
    logic          accept;
    logic          err_nxt;

    assign in_ready   = (state == FILL) & ~clr;
    assign accept     = in_valid & in_ready;
    assign idx        = auto_mode ? ptr : S;
    assign frame_done = (state == DONE);

    demux_dec u_dec (
        .sel      (idx),
        .onehot   (sel_oh),
        .in_range (sel_ok)
    );

    // An out-of-range select decodes to all zeros, so the word is simply dropped.
    assign wr_en = accept ? sel_oh : '0;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        lv_nxt    = lane_valid;
        err_nxt   = 1'b0;
        if (clr) begin
            state_nxt = FILL;
            ptr_nxt   = '0;
            lv_nxt    = '0;
        end else if (state == DONE) begin
            state_nxt = FILL;
            ptr_nxt   = '0;
            lv_nxt    = '0;
        end else if (accept) begin
            lv_nxt  = lane_valid | wr_en;
            err_nxt = ~sel_ok;
            if (auto_mode) ptr_nxt = ptr_next(ptr);
            if (&lv_nxt) state_nxt = DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            ptr        <= '0;
            lane_valid <= '0;
            err_sel    <= 1'b0;
            Q          <= '0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            lane_valid <= lv_nxt;
            err_sel    <= err_nxt;
            for (int k = 0; k < N; k++) begin
                if (wr_en[k]) Q[k*W +: W] <= D;
            end
        end
    end

endmodule

// File: tb/tb_demux_seq.sv
// Directed, table-driven bench for demux_seq with a behavioural muxN for loopback.
module tb_demux_seq;
    import demux_pkg::*;

    logic            clk;
    logic            rst;
    logic            clr;
    logic            auto_mode;
    logic [SW-1:0]   S;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    D;
    logic [N*W-1:0]  Q;
    logic [N-1:0]    lane_valid;
    logic            frame_done;
    logic            err_sel;

    int errors = 0;
    int checks = 0;

    demux_seq dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .auto_mode  (auto_mode),
        .S          (S),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .D          (D),
        .Q          (Q),
        .lane_valid (lane_valid),
        .frame_done (frame_done),
        .err_sel    (err_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic        am;
        logic [3:0]  s;
        logic        iv;
        logic [4:0]  d;
        logic        rdy;
        int          lane;
        logic [4:0]  lane_v;
        logic [9:0]  lv;
        logic        done;
        logic        err;
    } vec_t;

    vec_t vt [14];

    // Behavioural muxN: selects one lane of the frame bus.
    function automatic lane_t mux_n(input logic [N*W-1:0] q, input int s);
        if (s < 0 || s >= N) return '0;
        return q[s*W +: W];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic am, input logic [3:0] s,
                         input logic iv, input logic [4:0] d);
        @(negedge clk);
        clr       = c;
        auto_mode = am;
        S         = s;
        in_valid  = iv;
        D         = d;
    endtask

    lane_t frame_d [10];
    logic [9:0] frame_lv [10];
    lane_t exp_q [10];

    initial begin
        frame_d  = '{5'b10000, 5'b10001, 5'b00100, 5'b00010, 5'b00001,
                     5'b01010, 5'b01111, 5'b01010, 5'b00011, 5'b01000};
        frame_lv = '{10'h009, 10'h00B, 10'h00F, 10'h00F, 10'h01F,
                     10'h03F, 10'h07F, 10'h0FF, 10'h1FF, 10'h3FF};

        // manual write of lane 3
        vt[0] = '{1'b0, 1'b0, 4'd3, 1'b1, 5'b00010, 1'b1, 3, 5'b00010, 10'h008, 1'b0, 1'b0};
        // auto fill, ptr starting at 0
        for (int i = 0; i < 10; i++)
            vt[1+i] = '{1'b0, 1'b1, 4'd0, 1'b1, frame_d[i], 1'b1, i, frame_d[i],
                        frame_lv[i], (i == 9), 1'b0};
        // DONE cycle: beat refused, lane 9 untouched, frame restarts
        vt[11] = '{1'b0, 1'b1, 4'd0, 1'b1, 5'b11111, 1'b0, 9, 5'b01000, 10'h000, 1'b0, 1'b0};
        // bad manual select
        vt[12] = '{1'b0, 1'b0, 4'd12, 1'b1, 5'b11111, 1'b1, 2, 5'b00100, 10'h000, 1'b0, 1'b1};
        vt[13] = '{1'b0, 1'b0, 4'd12, 1'b0, 5'b11111, 1'b1, 2, 5'b00100, 10'h000, 1'b0, 1'b0};

        rst = 1'b1; clr = 1'b0; auto_mode = 1'b0; S = '0; in_valid = 1'b0; D = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_q", 64'(Q), 64'(0));
        chk("reset_lane_valid", 64'(lane_valid), 64'(0));
        chk("reset_in_ready", 64'(in_ready), 64'(1));
        chk("reset_frame_done", 64'(frame_done), 64'(0));
        chk("reset_err_sel", 64'(err_sel), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive(vt[i].clr, vt[i].am, vt[i].s, vt[i].iv, vt[i].d);
            #1;
            chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vt[i].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_lane%0d", i, vt[i].lane), 64'(mux_n(Q, vt[i].lane)), 64'(vt[i].lane_v));
            chk($sformatf("v%0d_lane_valid", i), 64'(lane_valid), 64'(vt[i].lv));
            chk($sformatf("v%0d_frame_done", i), 64'(frame_done), 64'(vt[i].done));
            chk($sformatf("v%0d_err_sel", i), 64'(err_sel), 64'(vt[i].err));
        end

        // loopback through muxN: every lane returns the word written in the auto frame
        for (int s = 0; s < N; s++) begin
            exp_q[s] = frame_d[s];
            chk($sformatf("loop_lane%0d", s), 64'(mux_n(Q, s)), 64'(exp_q[s]));
        end

        // clr mid-frame: four auto beats, then clr alongside a valid beat
        exp_q[0] = 5'b00111; exp_q[1] = 5'b01011; exp_q[2] = 5'b01101; exp_q[3] = 5'b01110;
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 4'd0, 1'b1, exp_q[i]);
        @(posedge clk);
        #1;
        chk("clr_pre_lane_valid", 64'(lane_valid), 64'(10'h00F));
        drive(1'b1, 1'b1, 4'd0, 1'b1, 5'b11111);
        #1;
        chk("clr_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        chk("clr_lane_valid", 64'(lane_valid), 64'(0));
        chk("clr_frame_done", 64'(frame_done), 64'(0));
        for (int k = 0; k < 5; k++)
            chk($sformatf("clr_keep_lane%0d", k), 64'(mux_n(Q, k)), 64'(exp_q[k]));
        drive(1'b0, 1'b1, 4'd0, 1'b1, 5'b10101);
        @(posedge clk);
        #1;
        chk("post_clr_lane0", 64'(mux_n(Q, 0)), 64'(5'b10101));
        chk("post_clr_lane1", 64'(mux_n(Q, 1)), 64'(exp_q[1]));
        chk("post_clr_lane_valid", 64'(lane_valid), 64'(10'h001));

        drive(1'b0, 1'b0, 4'd0, 1'b0, 5'b00000);
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
